// File: rtl/z_core_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : z_core_mem_arbiter
// Description : Shares one single-port, fixed-latency memory between the z_core
//               (port 0) and a DMA / debug loader (port 1). Round-robin
//               arbitration with a single transaction in flight.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk, reset               clock (rising edge), synchronous active-high reset
//   m0_*_i / m0_*_o          core port: req/we/addr/wdata in, gnt/rvalid/rdata out
//   m1_*_i / m1_*_o          DMA/debug port, same set as port 0
//   mem_en_o, mem_we_o       memory strobe and write enable (ISSUE cycle only)
//   mem_addr_o, mem_wdata_o  latched address / write data of current transaction
//   mem_rdata_i              memory read data, valid MEM_LATENCY cycles after issue
//   busy_o                   high whenever the arbiter is not idle
//------------------------------------------------------------------------------
module z_core_mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1    // legal range 1..15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam int             CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

   state_t              state_q, state_d;
   logic                rr_last_q, rr_last_d;   // port that won the last grant
   logic                owner_q, owner_d;       // port owning the transaction
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                gnt0, gnt1;

   // Grants are combinational in IDLE. On a tie the port that did not win
   // last time goes first; reset masks both grants so nothing is accepted
   // on the reset edge.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset && (state_q == ST_IDLE)) begin
         gnt0 = m0_req_i && (!m1_req_i || rr_last_q);
         gnt1 = m1_req_i && (!m0_req_i || !rr_last_q);
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt0 || gnt1) begin
               owner_d   = gnt1;
               rr_last_d = gnt1;
               we_d      = gnt1 ? m1_we_i    : m0_we_i;
               addr_d    = gnt1 ? m1_addr_i  : m0_addr_i;
               wdata_d   = gnt1 ? m1_wdata_i : m0_wdata_i;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // cnt==0 marks the cycle in which mem_rdata is valid; writes
            // return an all-zero acknowledge instead of memory data.
            if (cnt_q == '0) begin
               rdata_d = we_q ? '0 : mem_rdata_i;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rr_last_q <= 1'b1;
         owner_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
      end
   end

   // Address and write data simply hold the latched values; only the strobe
   // and write enable are restricted to the ISSUE cycle.
   assign mem_en_o    = (state_q == ST_ISSUE);
   assign mem_we_o    = (state_q == ST_ISSUE) && we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   assign m0_gnt_o    = gnt0;
   assign m1_gnt_o    = gnt1;
   assign m0_rvalid_o = (state_q == ST_RESP) && !owner_q;
   assign m1_rvalid_o = (state_q == ST_RESP) &&  owner_q;
   assign m0_rdata_o  = m0_rvalid_o ? rdata_q : '0;
   assign m1_rdata_o  = m1_rvalid_o ? rdata_q : '0;
   assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_z_core_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_z_core_mem_arbiter
// Description : Directed bench for z_core_mem_arbiter. Two instances: index 0
//               with MEM_LATENCY=1, index 1 with MEM_LATENCY=3, each with its
//               own small memory model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_z_core_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   // [dut][port]
   logic        req_in   [2][2];
   logic        we_in    [2][2];
   logic [31:0] addr_in  [2][2];
   logic [31:0] wdata_in [2][2];
   logic        gnt_out  [2][2];
   logic        rv_out   [2][2];
   logic [31:0] rd_out   [2][2];
   logic        mem_en   [2];
   logic        mem_we   [2];
   logic [31:0] mem_addr [2];
   logic [31:0] mem_wdata[2];
   logic [31:0] mem_rdata[2];
   logic        busy     [2];

   z_core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut_l1 (
      .clk(clk), .reset(rst),
      .m0_req_i(req_in[0][0]), .m0_we_i(we_in[0][0]), .m0_addr_i(addr_in[0][0]),
      .m0_wdata_i(wdata_in[0][0]), .m0_gnt_o(gnt_out[0][0]), .m0_rvalid_o(rv_out[0][0]),
      .m0_rdata_o(rd_out[0][0]),
      .m1_req_i(req_in[0][1]), .m1_we_i(we_in[0][1]), .m1_addr_i(addr_in[0][1]),
      .m1_wdata_i(wdata_in[0][1]), .m1_gnt_o(gnt_out[0][1]), .m1_rvalid_o(rv_out[0][1]),
      .m1_rdata_o(rd_out[0][1]),
      .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
      .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0]), .busy_o(busy[0])
   );

   z_core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u_dut_l3 (
      .clk(clk), .reset(rst),
      .m0_req_i(req_in[1][0]), .m0_we_i(we_in[1][0]), .m0_addr_i(addr_in[1][0]),
      .m0_wdata_i(wdata_in[1][0]), .m0_gnt_o(gnt_out[1][0]), .m0_rvalid_o(rv_out[1][0]),
      .m0_rdata_o(rd_out[1][0]),
      .m1_req_i(req_in[1][1]), .m1_we_i(we_in[1][1]), .m1_addr_i(addr_in[1][1]),
      .m1_wdata_i(wdata_in[1][1]), .m1_gnt_o(gnt_out[1][1]), .m1_rvalid_o(rv_out[1][1]),
      .m1_rdata_o(rd_out[1][1]),
      .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
      .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1]), .busy_o(busy[1])
   );

   // Memory models: data is valid for exactly one cycle, MEM_LATENCY cycles
   // after the strobe; writes return a junk pattern that must not be captured.
   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];
   logic [31:0] pa;
   logic [31:0] pb0, pb1, pb2;

   always @(posedge clk) begin
      if (rst) begin
         mem_a[8'h10] <= 32'hDEADBEEF;
      end else if (mem_en[0] && mem_we[0]) begin
         mem_a[mem_addr[0][7:0]] <= mem_wdata[0];
      end
      pa <= mem_en[0] ? (mem_we[0] ? 32'hBAD0BAD0 : mem_a[mem_addr[0][7:0]]) : 32'h0;
   end
   assign mem_rdata[0] = pa;

   always @(posedge clk) begin
      if (rst) begin
         mem_b[8'h04] <= 32'hCAFEF00D;
      end else if (mem_en[1] && mem_we[1]) begin
         mem_b[mem_addr[1][7:0]] <= mem_wdata[1];
      end
      pb0 <= mem_en[1] ? (mem_we[1] ? 32'hBAD0BAD0 : mem_b[mem_addr[1][7:0]]) : 32'h0;
      pb1 <= pb0;
      pb2 <= pb1;
   end
   assign mem_rdata[1] = pb2;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int d, input int p, input logic rq, input logic we,
                        input logic [31:0] a, input logic [31:0] wd);
      req_in[d][p]   = rq;
      we_in[d][p]    = we;
      addr_in[d][p]  = a;
      wdata_in[d][p] = wd;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One isolated transaction, checked cycle by cycle from T to T+L+3.
   task automatic run_txn(input int d, input int p, input logic we,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp);
      int lat = (d == 1) ? 3 : 1;
      @(negedge clk);
      drive(d, p, 1'b1, we, a, wd);
      #1;
      chk("gnt_own",   {31'b0, gnt_out[d][p]},   32'd1);
      chk("gnt_other", {31'b0, gnt_out[d][1-p]}, 32'd0);
      for (int k = 1; k <= lat + 3; k++) begin
         @(negedge clk);
         if (k == 1) drive(d, p, 1'b0, 1'b0, 32'h0, 32'h0);
         #1;
         chk("busy",   {31'b0, busy[d]},   (k <= lat + 2) ? 32'd1 : 32'd0);
         chk("mem_en", {31'b0, mem_en[d]}, (k == 1) ? 32'd1 : 32'd0);
         if (k == 1) begin
            chk("mem_we",    {31'b0, mem_we[d]}, {31'b0, we});
            chk("mem_addr",  mem_addr[d],  a);
            chk("mem_wdata", mem_wdata[d], wd);
         end else if (k <= lat + 1) begin
            chk("mem_we_wait", {31'b0, mem_we[d]}, 32'd0);
            chk("addr_hold",   mem_addr[d], a);
         end
         chk("rvalid_own",   {31'b0, rv_out[d][p]},   (k == lat + 2) ? 32'd1 : 32'd0);
         chk("rvalid_other", {31'b0, rv_out[d][1-p]}, 32'd0);
         chk("rdata_own",    rd_out[d][p], (k == lat + 2) ? exp : 32'h0);
      end
   endtask

   typedef struct {
      int          d;
      int          p;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int idx, last, rv0, rv1, waitc;

      vecs[0] = '{0, 0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
      vecs[1] = '{0, 1, 1'b1, 32'h20, 32'h12345678, 32'h0};
      vecs[2] = '{0, 0, 1'b0, 32'h20, 32'h0,        32'h12345678};
      vecs[3] = '{0, 1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
      vecs[4] = '{0, 0, 1'b1, 32'h30, 32'hA5A5A5A5, 32'h0};
      vecs[5] = '{0, 1, 1'b0, 32'h30, 32'h0,        32'hA5A5A5A5};
      vecs[6] = '{1, 0, 1'b0, 32'h04, 32'h0,        32'hCAFEF00D};
      vecs[7] = '{1, 1, 1'b1, 32'h08, 32'h0BADCAFE, 32'h0};
      vecs[8] = '{1, 1, 1'b0, 32'h08, 32'h0,        32'h0BADCAFE};

      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++)
            drive(d, p, 1'b0, 1'b0, 32'h0, 32'h0);

      // Reset state, with a request held to show gnt is masked by reset.
      drive(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
      idle(2);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_gnt0",   {31'b0, gnt_out[d][0]}, 32'd0);
         chk("rst_gnt1",   {31'b0, gnt_out[d][1]}, 32'd0);
         chk("rst_rv0",    {31'b0, rv_out[d][0]},  32'd0);
         chk("rst_rv1",    {31'b0, rv_out[d][1]},  32'd0);
         chk("rst_rd0",    rd_out[d][0], 32'h0);
         chk("rst_rd1",    rd_out[d][1], 32'h0);
         chk("rst_mem_en", {31'b0, mem_en[d]}, 32'd0);
         chk("rst_mem_we", {31'b0, mem_we[d]}, 32'd0);
         chk("rst_addr",   mem_addr[d],  32'h0);
         chk("rst_wdata",  mem_wdata[d], 32'h0);
         chk("rst_busy",   {31'b0, busy[d]}, 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);

      // Single transactions on both latencies.
      for (int i = 0; i < 9; i++)
         run_txn(vecs[i].d, vecs[i].p, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

      // Tie after reset: grants must alternate m0,m1,m0,m1 every 4 cycles.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      drive(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
      drive(0, 1, 1'b1, 1'b0, 32'h30, 32'h0);
      idx = 0; last = 0; rv0 = 0; rv1 = 0;
      for (int c = 0; c < 40 && idx < 4; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         chk("tie_two_gnt", {31'b0, gnt_out[0][0] & gnt_out[0][1]}, 32'd0);
         if (gnt_out[0][0] || gnt_out[0][1]) begin
            chk("tie_order", {31'b0, gnt_out[0][1]}, (idx % 2 == 1) ? 32'd1 : 32'd0);
            if (idx > 0) chk("tie_spacing", c - last, 32'd4);
            last = c;
            idx++;
         end
         if (rv_out[0][0]) begin rv0++; chk("tie_rd0", rd_out[0][0], 32'hDEADBEEF); end
         if (rv_out[0][1]) begin rv1++; chk("tie_rd1", rd_out[0][1], 32'hA5A5A5A5); end
      end
      chk("tie_grants", idx, 32'd4);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) begin
            drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
            drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
         end
         #1;
         if (rv_out[0][0]) begin rv0++; chk("tie_rd0", rd_out[0][0], 32'hDEADBEEF); end
         if (rv_out[0][1]) begin rv1++; chk("tie_rd1", rd_out[0][1], 32'hA5A5A5A5); end
      end
      chk("tie_rv0_count", rv0, 32'd2);
      chk("tie_rv1_count", rv1, 32'd2);

      // m1 arrives while m0 is busy; once idle m1 beats a fresh m0 request.
      @(negedge clk);
      drive(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
      #1;
      chk("busy_m0_gnt", {31'b0, gnt_out[0][0]}, 32'd1);
      @(negedge clk);
      drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(0, 1, 1'b1, 1'b0, 32'h20, 32'h0);
      for (int k = 1; k <= 3; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         chk("busy_m1_wait", {31'b0, gnt_out[0][1]}, 32'd0);
      end
      @(negedge clk);
      drive(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
      #1;
      chk("busy_m1_gnt",  {31'b0, gnt_out[0][1]}, 32'd1);
      chk("busy_m0_lose", {31'b0, gnt_out[0][0]}, 32'd0);
      @(negedge clk);
      drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
      waitc = 0;
      #1;
      while (!gnt_out[0][0] && waitc < 12) begin
         @(negedge clk);
         #1;
         waitc++;
      end
      chk("busy_m0_later", waitc, 32'd3);
      @(negedge clk);
      drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(5);

      // Reset in WAIT of an m1 read: no response, clean return to IDLE.
      @(negedge clk);
      drive(0, 1, 1'b1, 1'b0, 32'h10, 32'h0);
      #1;
      chk("abort_gnt", {31'b0, gnt_out[0][1]}, 32'd1);
      @(negedge clk);
      drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      #1;
      chk("abort_wait_busy", {31'b0, busy[0]}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("abort_busy",   {31'b0, busy[0]},      32'd0);
      chk("abort_mem_en", {31'b0, mem_en[0]},    32'd0);
      chk("abort_rvalid", {31'b0, rv_out[0][1]}, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("abort_no_rvalid", {31'b0, rv_out[0][1]}, 32'd0);
      end
      run_txn(0, 1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
